mult_sched: RTL and testbench

MULT_SCHED -- requirements
Module: mult_sched

---
 rtl/mult_sched.sv | 156 +++++++++++++++
 tb/tb_mult_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler that time-shares one 32x32 signed
// combinational multiplier between two requesters. Each operation is accepted
// from one requester and allowed MUL_CYCLES settle cycles in the tree. The
// registered 64-bit product is then returned on the owner's response channel.

// Shared signed tree multiplier. The scheduler treats it as purely
// combinational. The settle time it needs is what MUL_CYCLES covers.
module mult_tree (
  input  logic signed [31:0] i_a,
  input  logic signed [31:0] i_b,
  output logic signed [63:0] o_p
);

  // Full-width signed product; both operands are sign-extended to 64 bits.
  assign o_p = i_a * i_b;

endmodule

module mult_sched #(
  parameter int unsigned MUL_CYCLES = 2   // multiplier settle cycles, 1..8
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  // requester 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  // responses
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Three bits hold MUL_CYCLES-1 for the whole legal range of 1..8.
  localparam int unsigned         CNT_W    = 3;
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_prio;       // requester favoured on a tie
  logic                r_owner;      // requester that owns the operation
  logic signed [31:0]  r_a;
  logic signed [31:0]  r_b;
  logic [CNT_W-1:0]    r_cnt;
  logic [63:0]         r_rsp_data;

  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_accept;
  logic                w_cnt_zero;
  logic                w_rsp_hs;
  logic signed [63:0]  w_product;

  // The only multiplier, fed solely from the operand registers so the
  // request ports may change freely while the tree settles.
  mult_tree u_mult (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_product)
  );

  // Round-robin grant: a lone valid wins outright, a tie goes to r_prio.
  always_comb begin
    w_gnt0 = req0_valid & (~req1_valid | ~r_prio);
    w_gnt1 = req1_valid & (~req0_valid |  r_prio);
  end

  // The grant is combinational from the valids and the FSM already sits in
  // IDLE under reset, so rst_n gates acceptance to keep ready low in reset.
  assign w_accept   = (r_state == IDLE) & rst_n & (w_gnt0 | w_gnt1);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_rsp_hs   = r_owner ? rsp1_ready : rsp0_ready;
  assign rsp_data   = r_rsp_data;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = rst_n & w_gnt0;
        req1_ready = rst_n & w_gnt1;
        if (w_accept) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_cnt_zero) w_state_nxt = DONE;
      end
      DONE: begin
        rsp0_valid = ~r_owner;
        rsp1_valid =  r_owner;
        if (w_rsp_hs) w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, arbitration pointer, settle counter and product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_owner    <= 1'b0;
      r_prio     <= 1'b0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
    end else if (w_accept) begin
      r_a     <= w_gnt1 ? req1_a : req0_a;
      r_b     <= w_gnt1 ? req1_b : req0_b;
      r_owner <= w_gnt1;
      r_prio  <= ~w_gnt1;     // the requester just served loses the next tie
      r_cnt   <= CNT_LOAD;
    end else if (r_state == BUSY) begin
      if (w_cnt_zero) begin
        r_rsp_data <= w_product;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: three schedulers (MUL_CYCLES = 1, 2, 8) with separate
// stimulus and a shared reset. A transaction-level model tracks each one. Its
// outputs are compared with the model on every falling edge, and directed
// tests pin literal products, latencies and grant order.
module tb_mult_sched;

  localparam int NI = 3;
  localparam int unsigned MC [NI] = '{1, 2, 8};

  logic clk = 1'b0;
  logic rst_n;

  logic [NI-1:0] v0, v1, rr0, rr1;
  logic [NI-1:0] rdy0, rdy1, rv0, rv1, bsy;
  logic [31:0]   a0 [NI];
  logic [31:0]   b0 [NI];
  logic [31:0]   a1 [NI];
  logic [31:0]   b1 [NI];
  logic [63:0]   rd [NI];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mult_sched #(.MUL_CYCLES(MC[g])) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (v0[g]),
      .req0_ready (rdy0[g]),
      .req0_a     (a0[g]),
      .req0_b     (b0[g]),
      .req1_valid (v1[g]),
      .req1_ready (rdy1[g]),
      .req1_a     (a1[g]),
      .req1_b     (b1[g]),
      .rsp0_valid (rv0[g]),
      .rsp0_ready (rr0[g]),
      .rsp1_valid (rv1[g]),
      .rsp1_ready (rr1[g]),
      .rsp_data   (rd[g]),
      .busy       (bsy[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sprod(input logic [31:0] a, input logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  // Grant rule as a one-hot {req1, req0}.
  function automatic logic [1:0] pick(input logic q0, input logic q1, input logic prio);
    if (q0 && q1) return prio ? 2'b10 : 2'b01;
    return {q1, q0};
  endfunction

  // ---------------- transaction-level model ----------------
  // An operation is "in flight" from its accept edge until the response
  // handshake edge. Its age counts edges since acceptance, and the product
  // becomes visible once the age reaches MUL_CYCLES.
  bit          m_busy  [NI];
  bit          m_owner [NI];
  bit          m_prio  [NI];
  int          m_age   [NI];
  logic [63:0] m_prod  [NI];
  logic [63:0] m_data  [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        m_busy[k] = 1'b0; m_owner[k] = 1'b0; m_prio[k] = 1'b0;
        m_age[k] = 0; m_prod[k] = '0; m_data[k] = '0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        logic [1:0] g;
        if (!m_busy[k]) begin
          g = pick(v0[k], v1[k], m_prio[k]);
          if (g != 2'b00) begin
            m_busy[k]  = 1'b1;
            m_owner[k] = g[1];
            m_prio[k]  = ~g[1];
            m_age[k]   = 0;
            m_prod[k]  = g[1] ? sprod(a1[k], b1[k]) : sprod(a0[k], b0[k]);
          end
        end else if (m_age[k] < int'(MC[k])) begin
          m_age[k]++;
          if (m_age[k] == int'(MC[k])) m_data[k] = m_prod[k];
        end else if (m_owner[k] ? rr1[k] : rr0[k]) begin
          m_busy[k] = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      logic [1:0] er;
      logic       done;
      er   = (rst_n && !m_busy[k]) ? pick(v0[k], v1[k], m_prio[k]) : 2'b00;
      done = m_busy[k] && (m_age[k] >= int'(MC[k]));
      check($sformatf("i%0d_busy", k), bsy[k], m_busy[k]);
      check($sformatf("i%0d_req0_ready", k), rdy0[k], er[0]);
      check($sformatf("i%0d_req1_ready", k), rdy1[k], er[1]);
      check($sformatf("i%0d_rsp0_valid", k), rv0[k], done && !m_owner[k]);
      check($sformatf("i%0d_rsp1_valid", k), rv1[k], done && m_owner[k]);
      check($sformatf("i%0d_rsp_data", k), rd[k], m_data[k]);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present an operand pair and hold valid until the handshake edge.
  // acc returns the edge count just after acceptance, or -1 on timeout.
  task automatic issue(input int k, input bit who, input logic [31:0] a,
                       input logic [31:0] b, output int acc);
    @(posedge clk); #1;
    if (who) begin a1[k] = a; b1[k] = b; v1[k] = 1'b1; end
    else     begin a0[k] = a; b0[k] = b; v0[k] = 1'b1; end
    acc = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if ((who ? rdy1[k] : rdy0[k]) === 1'b1) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
    end
    if (who) v1[k] = 1'b0; else v0[k] = 1'b0;
    check($sformatf("i%0d_accepted", k), (acc >= 0), 1'b1);
  endtask

  // Wait for the owner's response, optionally stall it for hold cycles while
  // checking stability, then consume it.
  task automatic wait_rsp(input int k, input bit who, input int acc, input int hold,
                          output logic [63:0] data, output int lat);
    lat  = -1;
    data = '0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if ((who ? rv1[k] : rv0[k]) === 1'b1) begin
        lat  = cyc - acc;
        data = rd[k];
        check($sformatf("i%0d_other_rsp_quiet", k), (who ? rv0[k] : rv1[k]), 1'b0);
        break;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("i%0d_hold_valid", k), (who ? rv1[k] : rv0[k]), 1'b1);
      check($sformatf("i%0d_hold_data", k), rd[k], data);
      check($sformatf("i%0d_hold_ready", k), {rdy1[k], rdy0[k]}, 2'b00);
      check($sformatf("i%0d_hold_busy", k), bsy[k], 1'b1);
    end
    if (who) rr1[k] = 1'b1; else rr0[k] = 1'b1;
    @(posedge clk); #1;
    if (who) rr1[k] = 1'b0; else rr0[k] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          acc, lat;
    logic [63:0] data;
    int          order [$];
    logic [31:0] ra, rb;
    bit          who;

    rst_n = 1'b0;
    v0 = '0; v1 = '0; rr0 = '0; rr1 = '0;
    for (int k = 0; k < NI; k++) begin
      a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
    end

    // Reset state.
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("i%0d_rst_outputs", k),
            {rdy0[k], rdy1[k], rv0[k], rv1[k], bsy[k]}, 5'b0);
      check($sformatf("i%0d_rst_data", k), rd[k], 64'h0);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Contention on MUL_CYCLES=2: both valid for four operations.
    rr0[1] = 1'b1; rr1[1] = 1'b1;
    a0[1] = 32'd5;  b0[1] = 32'd6;
    a1[1] = -32'sd2; b1[1] = 32'd9;
    @(posedge clk); #1;
    v0[1] = 1'b1; v1[1] = 1'b1;
    for (int t = 0; t < 80 && order.size() < 4; t++) begin
      @(negedge clk);
      if (rv0[1]) check("cont_rsp0_data", rd[1], 64'h0000_0000_0000_001E);
      if (rv1[1]) check("cont_rsp1_data", rd[1], 64'hFFFF_FFFF_FFFF_FFEE);
      if (rdy0[1]) order.push_back(0);
      else if (rdy1[1]) order.push_back(1);
      if (order.size() == 4) begin
        @(posedge clk); #1;
        v0[1] = 1'b0; v1[1] = 1'b0;
      end
    end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rv0[1]) check("cont_rsp0_data", rd[1], 64'h0000_0000_0000_001E);
      if (rv1[1]) check("cont_rsp1_data", rd[1], 64'hFFFF_FFFF_FFFF_FFEE);
      if (!bsy[1]) break;
    end
    v0[1] = 1'b0; v1[1] = 1'b0;
    rr0[1] = 1'b0; rr1[1] = 1'b0;
    check("cont_grant_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++)
      check($sformatf("cont_grant%0d", i), order[i], i % 2);

    // Single request on req0: -3 * 7.
    issue(1, 1'b0, -32'sd3, 32'd7, acc);
    wait_rsp(1, 1'b0, acc, 0, data, lat);
    check("single_data", data, 64'hFFFF_FFFF_FFFF_FFEB);
    check("single_latency", lat, 2);

    // Corner operands.
    issue(1, 1'b1, 32'h8000_0000, 32'h8000_0000, acc);
    wait_rsp(1, 1'b1, acc, 0, data, lat);
    check("corner_minmin", data, 64'h4000_0000_0000_0000);
    issue(1, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, acc);
    wait_rsp(1, 1'b1, acc, 0, data, lat);
    check("corner_max_neg1", data, 64'hFFFF_FFFF_8000_0001);
    issue(1, 1'b0, 32'h0, 32'h1234_5678, acc);
    wait_rsp(1, 1'b0, acc, 0, data, lat);
    check("corner_zero", data, 64'h0);

    // Backpressure on rsp1 with request traffic and stray rsp0_ready.
    issue(1, 1'b1, 32'd1000, 32'hFFFF_FFFE, acc);
    v0[1] = 1'b1; v1[1] = 1'b1; rr0[1] = 1'b1;
    a0[1] = 32'd7; b0[1] = 32'd7;
    wait_rsp(1, 1'b1, acc, 5, data, lat);
    check("bp_data", data, 64'hFFFF_FFFF_FFFF_F830);
    check("bp_latency", lat, 2);
    check("bp_idle_after_release", bsy[1], 1'b0);
    check("bp_ready_after_release", {rdy1[1], rdy0[1]}, 2'b01);
    v0[1] = 1'b0; v1[1] = 1'b0; rr0[1] = 1'b0;

    // Reset mid-BUSY on MUL_CYCLES=8, after req0 was served so the pointer
    // favours req1 until reset restores it.
    issue(2, 1'b0, 32'd11, 32'd13, acc);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    v0[2] = 1'b1; v1[2] = 1'b1;
    #1;
    check("rst_mid_outputs", {rdy0[2], rdy1[2], rv0[2], rv1[2], bsy[2]}, 5'b0);
    check("rst_mid_data", rd[2], 64'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tie_req0_wins", {rdy1[2], rdy0[2]}, 2'b01);
    @(posedge clk); #1;
    acc = cyc;
    v0[2] = 1'b0; v1[2] = 1'b0;
    wait_rsp(2, 1'b0, acc, 0, data, lat);
    check("rst_next_data", data, 64'h0000_0000_0000_008F);
    check("rst_next_latency", lat, 8);

    // Parameter sweep with random signed operands.
    for (int s = 0; s < 2; s++) begin
      int k;
      k = (s == 0) ? 0 : 2;
      for (int i = 0; i < 6; i++) begin
        who = 1'($urandom_range(0, 1));
        ra  = $urandom;
        rb  = $urandom;
        issue(k, who, ra, rb, acc);
        wait_rsp(k, who, acc, 0, data, lat);
        check($sformatf("sweep_i%0d_data%0d", k, i), data, sprod(ra, rb));
        check($sformatf("sweep_i%0d_latency%0d", k, i), lat, MC[k]);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
